display_scan: RTL and testbench
===============================

# display_scan

Time-multiplexed 4-digit 7-segment display scheduler for the hero game. Shares one segment bus among four sources (hero glyph, obstacle glyph, letter glyph, game-status glyph), driving active-low one-hot anodes with a fixed per-digit dwell and an anti-ghosting blanking guard. Sits beside `fsm` and `keypad` in `top`, consuming the `heroe`, `obstaculo`, `letra_out`, `estado`, `W_or_L` and `fsm_error` nets and driving the board display pins.

## Interface
- `REFRESH_DIV`, 50000: clock cycles per digit slot; legal range is 4 or more.
- `GUARD`, 16: blanked cycles at the start of each slot; legal range is 1 to `REFRESH_DIV`-1.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `heroe` input 7: slot-0 segment pattern `{g,f,e,d,c,b,a}`, active-high.
- `obstaculo` input 7: slot-1 segment pattern.
- `letra_out` input 7: slot-2 segment pattern.
- `estado` input 3: FSM state, shown as a decimal digit in slot 3.
- `W_or_L` input 2: `01` win, `10` loss, `00` playing, `11` invalid.
- `fsm_error` input 1: FSM error flag.
- `seg` output 7: registered segment bus, active-high.
- `an` output 4: registered anodes, active-low, one-hot or all-high.
- `slot` output 2: current slot index.

## Operation
- Dwell counter `cnt`:
  - Counts 0 to `REFRESH_DIV`-1.
  - At the terminal count it wraps to 0 and `slot` increments.
  - Slot sequence is 0→1→2→3→0.
- `seg` is loaded every cycle from the current slot's source:
  - Slot 0: `heroe`.
  - Slot 1: `obstaculo`.
  - Slot 2: `letra_out`.
  - Slot 3: the status glyph.
- Status glyph, in priority order:
  - `fsm_error`=1 or `W_or_L`=11: 'E' = 1111001.
  - `W_or_L`=01: 'G' = 0111101.
  - `W_or_L`=10: 'L' = 0111000.
  - Otherwise, the `estado` digit:
    - 0=0111111, 1=0000110, 2=1011011, 3=1001111.
    - 4=1100110, 5=1101101, 6=1111101, 7=0000111.
- Anodes:
  - `an`=1111 while `cnt` < `GUARD`.
  - Otherwise `an` = ~(1<<`slot`).
- Source inputs may change at any time; `seg` tracks them with 1-cycle latency and no slot disturbance.
- Only `rst` resets the scheduler; no input stalls it.

## Timing
- Reset values:
  - `cnt`=0, `slot`=0, `an`=1111.
  - `seg`=0000000, blink phase = on.
- Reset asserted mid-slot:
  - Outputs go to reset values immediately, asynchronously.
  - After deassert, scanning restarts at slot 0, `cnt`=0.
- Input-to-`seg` latency: 1 clock.
- `slot` changes on the clock edge after `cnt`=`REFRESH_DIV`-1. On that same edge:
  - `cnt` becomes 0.
  - `an` goes to 1111 (guard).
- `an` turns on the edge where `cnt` becomes `GUARD`.
- Each digit is lit for `REFRESH_DIV`-`GUARD` cycles per slot.
- One frame is 4×`REFRESH_DIV` cycles.
- `seg` is already stable on the new slot's source for `GUARD`-1 cycles before its anode enables, so no ghosting.

## Configuration
- Macro: `DISPLAY_SCAN_BLINK_EN`.
- When defined:
  - A 5-bit frame counter increments at each slot-3→0 wrap.
  - While `W_or_L` is 01 or 10, blink phase = frame counter bit 4.
  - When the phase is off, `an` is forced to 1111 for whole frames. The rate is 16 frames on, 16 frames off.
  - When `W_or_L` leaves 01/10, the phase is forced on and the frame counter cleared on the next clock.
  - `fsm_error` does not blink.
- When undefined:
  - No frame counter.
  - The display is always steady, as described in Operation.

## Test plan
Benches use `REFRESH_DIV`=8, `GUARD`=2.

- Reset, then release, then run 40 cycles:
  - `an`=1111 during cycles 0–1 of each slot.
  - `an` then reads 1110, 1101, 1011, 0111 for cycles 2–7 of slots 0–3.
  - `slot` wraps 3→0 at cycle 32.
- Source mux, with `heroe`=0000110, `obstaculo`=1011011, `letra_out`=1110111:
  - While each respective anode is low, `seg` equals the matching pattern.
- Status glyph, in slot 3, cycling `W_or_L`=01/10/00 with `estado`=5:
  - `seg` = 0111101, then 0111000, then 1101101.
  - With `fsm_error`=1, `seg`=1111001 regardless of `W_or_L`.
- Reset asserted at `slot`=2, `cnt`=5:
  - Same cycle: `an`=1111, `seg`=0.
  - After release: slot 0 anode lights 2 cycles later.
- Source glitch: toggle `heroe` during slot 2.
  - `seg` is unaffected until slot 0.
  - In slot 0, `seg` reflects the new value 1 cycle after it is applied.
- With `DISPLAY_SCAN_BLINK_EN` and `W_or_L`=01:
  - Frames 0–15 scan normally.
  - Frames 16–31 hold `an`=1111.
  - Dropping `W_or_L` to 00 mid-blank restores scanning on the next clock.

Source files
------------

// File: rtl/display_scan.sv
// display_scan: time-multiplexed 4-digit 7-segment scheduler.
// Shares one segment bus among the hero, obstacle, letter and game-status
// glyphs. Anodes are active-low and one-hot, and a blanking guard at the
// start of every slot prevents ghosting.
// Optional feature macro: DISPLAY_SCAN_BLINK_EN (blinks the display at the
// end of a game, 16 frames on and 16 frames off).
module display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] heroe,
    input  logic [6:0] obstaculo,
    input  logic [6:0] letra_out,
    input  logic [2:0] estado,
    input  logic [1:0] W_or_L,
    input  logic       fsm_error,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [1:0] slot
);

    localparam int              CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       slot_next;
    logic [6:0]       status_glyph;
    logic [6:0]       seg_next;
    logic [3:0]       an_next;
    logic             blink_off;

    // Dwell counter advance; the slot moves on at the terminal count.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cnt_next  = cnt + 1'b1;
        slot_next = slot;
        if (cnt == CNT_LAST) begin
            cnt_next  = '0;
            slot_next = slot + 2'd1;
        end
    end

    // Status glyph: error beats win/loss, which beats the state digit.
    always_comb begin
        status_glyph = 7'b0000000;
        if (fsm_error || W_or_L == 2'b11) begin
            status_glyph = 7'b1111001;              // E
        end else if (W_or_L == 2'b01) begin
            status_glyph = 7'b0111101;              // G
        end else if (W_or_L == 2'b10) begin
            status_glyph = 7'b0111000;              // L
        end else begin
            case (estado)
                3'd0:    status_glyph = 7'b0111111;
                3'd1:    status_glyph = 7'b0000110;
                3'd2:    status_glyph = 7'b1011011;
                3'd3:    status_glyph = 7'b1001111;
                3'd4:    status_glyph = 7'b1100110;
                3'd5:    status_glyph = 7'b1101101;
                3'd6:    status_glyph = 7'b1111101;
                default: status_glyph = 7'b0000111;
            endcase
        end
    end

    // Segment source selected by the current slot. The bus changes source one
    // cycle into the new slot, well inside the blanked guard window.
    always_comb begin
        seg_next = heroe;
        case (slot)
            2'd0:    seg_next = heroe;
            2'd1:    seg_next = obstaculo;
            2'd2:    seg_next = letra_out;
            default: seg_next = status_glyph;
        endcase
    end

`ifdef DISPLAY_SCAN_BLINK_EN
    logic [4:0] frame;
    logic [4:0] frame_next;
    logic       game_over;

    // Frame counter runs only while a win/loss is shown. Leaving that state
    // clears it, which also forces the blink phase back on.
    always_comb begin
        game_over  = (W_or_L == 2'b01 || W_or_L == 2'b10) && !fsm_error;
        frame_next = frame;
        if (!game_over) begin
            frame_next = '0;
        end else if (cnt == CNT_LAST && slot == 2'd3) begin
            frame_next = frame + 5'd1;
        end
        blink_off = game_over && frame_next[4];
    end

    // Frame counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame <= '0;
        end else begin
            frame <= frame_next;
        end
    end
`else
    // Steady display: the blink phase is always on.
    always_comb begin
        blink_off = 1'b0;
    end
`endif

    // Anodes follow the position being entered, so they switch on exactly at
    // the edge where the counter reaches the end of the guard.
    always_comb begin
        an_next = ~(4'b0001 << slot_next);
        if (cnt_next < GUARD_C || blink_off) begin
            an_next = 4'b1111;
        end
    end

    // Scheduler state and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            slot <= 2'd0;
            seg  <= 7'b0000000;
            an   <= 4'b1111;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            cnt  <= cnt_next;
            slot <= slot_next;
            seg  <= seg_next;
            an   <= an_next;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Directed testbench for display_scan with REFRESH_DIV=8, GUARD=2.
// A cycle counter since the last reset release gives the expected slot and
// dwell position; expected glyphs are hand-written constants.
module tb_display_scan;

    localparam int RD = 8;
    localparam int GD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] heroe     = 7'b0000110;
    logic [6:0] obstaculo = 7'b1011011;
    logic [6:0] letra_out = 7'b1110111;
    logic [2:0] estado    = 3'd5;
    logic [1:0] W_or_L    = 2'b00;
    logic       fsm_error = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] slot;

    int passed = 0;
    int total  = 0;
    int tb_cyc = 0;

    display_scan #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
        .clk       (clk),
        .rst       (rst),
        .heroe     (heroe),
        .obstaculo (obstaculo),
        .letra_out (letra_out),
        .estado    (estado),
        .W_or_L    (W_or_L),
        .fsm_error (fsm_error),
        .seg       (seg),
        .an        (an),
        .slot      (slot)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (time %0t, required < 1000000)", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] exp_an(input int cyc, input logic blank);
        int c;
        int s;
        c = cyc % RD;
        s = (cyc / RD) % 4;
        if (c < GD || blank) return 4'b1111;
        return ~(4'b0001 << s);
    endfunction

    // One clock edge, then settle to the falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        tb_cyc++;
    endtask

    // Step until the expected position is (s, c), bounded.
    task automatic advance_to(input int s, input int c);
        int n;
        n = 0;
        while (!((tb_cyc % RD) == c && ((tb_cyc / RD) % 4) == s) && n < 64) begin
            step();
            n++;
        end
        total++;
        if ((tb_cyc % RD) == c && ((tb_cyc / RD) % 4) == s) passed++;
        else $display("FAIL advance_to: position not reached (cyc %0d, required slot %0d cnt %0d)", tb_cyc, s, c);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        tb_cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        total++;
        if (an === 4'b1111) passed++;
        else $display("FAIL reset_an: got %b, required 1111", an);
        total++;
        if (seg === 7'b0000000) passed++;
        else $display("FAIL reset_seg: got %b, required 0000000", seg);
        total++;
        if (slot === 2'd0) passed++;
        else $display("FAIL reset_slot: got %0d, required 0", slot);
        release_reset();
    endtask

    task automatic test_scan();
        for (int i = 0; i < 40; i++) begin
            step();
            total++;
            if (an === exp_an(tb_cyc, 1'b0)) passed++;
            else $display("FAIL scan_an cyc %0d: got %b, required %b", tb_cyc, an, exp_an(tb_cyc, 1'b0));
            total++;
            if (slot === 2'((tb_cyc / RD) % 4)) passed++;
            else $display("FAIL scan_slot cyc %0d: got %0d, required %0d", tb_cyc, slot, (tb_cyc / RD) % 4);
        end
    endtask

    task automatic test_source_mux();
        logic [6:0] src [4];
        src[0] = 7'b0000110;
        src[1] = 7'b1011011;
        src[2] = 7'b1110111;
        src[3] = 7'b1101101;   // estado 5, playing
        for (int s = 0; s < 4; s++) begin
            advance_to(s, GD);
            for (int c = GD; c < RD; c++) begin
                if (c > GD) step();
                total++;
                if (an === exp_an(tb_cyc, 1'b0) && seg === src[s]) passed++;
                else $display("FAIL mux slot %0d cnt %0d: got seg %b an %b, required seg %b an %b",
                              s, c, seg, an, src[s], exp_an(tb_cyc, 1'b0));
            end
        end
    endtask

    task automatic test_status();
        logic [1:0] wl_v  [7];
        logic       err_v [7];
        logic [6:0] exp_v [7];
        logic [6:0] dig_v [8];
        wl_v  = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b00, 2'b01, 2'b10};
        err_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_v = '{7'b0111101, 7'b0111000, 7'b1101101, 7'b1111001,
                  7'b1111001, 7'b1111001, 7'b1111001};
        dig_v = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                  7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111};
        estado = 3'd5;
        advance_to(3, 0);
        for (int i = 0; i < 7; i++) begin
            W_or_L = wl_v[i];
            fsm_error = err_v[i];
            step();
            total++;
            if (seg === exp_v[i]) passed++;
            else $display("FAIL status wl=%b err=%b: got %b, required %b", wl_v[i], err_v[i], seg, exp_v[i]);
        end
        W_or_L = 2'b00;
        fsm_error = 1'b0;
        advance_to(3, 0);
        for (int d = 0; d < 8; d++) begin
            estado = 3'(d);
            step();
            total++;
            if (seg === dig_v[d]) passed++;
            else $display("FAIL status_digit %0d: got %b, required %b", d, seg, dig_v[d]);
        end
        estado = 3'd5;
    endtask

    task automatic test_reset_mid();
        advance_to(2, 5);
        rst = 1'b1;
        #1;
        total++;
        if (an === 4'b1111 && seg === 7'b0000000 && slot === 2'd0) passed++;
        else $display("FAIL reset_mid: got an %b seg %b slot %0d, required 1111 0000000 0", an, seg, slot);
        release_reset();
        step();
        total++;
        if (an === 4'b1111) passed++;
        else $display("FAIL reset_mid_guard: got %b, required 1111", an);
        step();
        total++;
        if (an === 4'b1110) passed++;
        else $display("FAIL reset_mid_light: got %b, required 1110", an);
    endtask

    task automatic test_glitch();
        advance_to(2, 3);
        for (int i = 0; i < 3; i++) begin
            heroe = ~heroe;
            step();
            total++;
            if (seg === 7'b1110111) passed++;
            else $display("FAIL glitch_slot2 step %0d: got %b, required 1110111", i, seg);
        end
        advance_to(0, GD);
        total++;
        if (seg === 7'b1111001) passed++;
        else $display("FAIL glitch_slot0: got %b, required 1111001", seg);
        heroe = 7'b0101010;
        #1;
        total++;
        if (seg === 7'b1111001) passed++;
        else $display("FAIL glitch_hold: got %b, required 1111001", seg);
        step();
        total++;
        if (seg === 7'b0101010) passed++;
        else $display("FAIL glitch_latency: got %b, required 0101010", seg);
    endtask

`ifdef DISPLAY_SCAN_BLINK_EN
    task automatic test_blink();
        logic blank;
        rst = 1'b1;
        W_or_L = 2'b01;
        fsm_error = 1'b0;
        #12;
        release_reset();
        for (int i = 0; i < 20 * 4 * RD + 12; i++) begin
            step();
            blank = ((tb_cyc / (4 * RD)) % 32) >= 16;
            total++;
            if (an === exp_an(tb_cyc, blank)) passed++;
            else $display("FAIL blink_an cyc %0d: got %b, required %b", tb_cyc, an, exp_an(tb_cyc, blank));
        end
        W_or_L = 2'b00;
        step();
        total++;
        if (an === 4'b1101) passed++;
        else $display("FAIL blink_restore: got %b, required 1101", an);
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_source_mux();
        test_status();
        test_reset_mid();
        test_glitch();
`ifdef DISPLAY_SCAN_BLINK_EN
        test_blink();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
